// File: rtl/alu.sv
// Registered 32-bit execute-stage ALU: nine operations selected by ALUControl,
// result and zero flag captured one clock after a valid input.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             out_valid
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    logic [SHW-1:0]   shamt_s;
    logic [WIDTH-1:0] result_s;
    logic             zero_s;

    // Operation decode; unassigned codes yield zero so Zero reads back as 1.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        shamt_s  = B[SHW-1:0];
        case (ALUControl)
            OP_AND:  result_s = A & B;
            OP_OR:   result_s = A | B;
            OP_ADD:  result_s = A + B;
            OP_XOR:  result_s = A ^ B;
            OP_SUB:  result_s = A - B;
            OP_SLT: begin
                if ($signed(A) < $signed(B)) begin
                    result_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    result_s = {WIDTH{1'b0}};
                end
            end
            OP_SLL:  result_s = A << shamt_s;
            OP_SRL:  result_s = A >> shamt_s;
            OP_SRA:  result_s = $unsigned($signed(A) >>> shamt_s);
            default: result_s = {WIDTH{1'b0}};
        endcase
    end

    // Zero flag from the freshly computed value, not the stale register.
    always_comb begin
        zero_s = (result_s == {WIDTH{1'b0}});
    end

    // Output registers: capture on in_valid, otherwise hold and drop out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result    <= {WIDTH{1'b0}};
            Zero      <= 1'b1;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            Result    <= result_s;
            Zero      <= zero_s;
            out_valid <= 1'b1;
        end else begin
            Result    <= Result;
            Zero      <= Zero;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus randomized traffic against
// an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUControl;
    logic [31:0] Result;
    logic        Zero;
    logic        out_valid;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_ov;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .A          (A),
        .B          (B),
        .ALUControl (ALUControl),
        .Result     (Result),
        .Zero       (Zero),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        longint sa;
        sh = b % 32;
        sa = longint'($signed(a));
        if (c == 4'd0)       return a & b;
        else if (c == 4'd1)  return a | b;
        else if (c == 4'd2)  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
        else if (c == 4'd3)  return a ^ b;
        else if (c == 4'd6)  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
        else if (c == 4'd7)  return (sa < longint'($signed(b))) ? 32'd1 : 32'd0;
        else if (c == 4'd8)  return 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
        else if (c == 4'd9)  return 32'(64'(a) / (64'd1 << sh));
        else if (c == 4'd10) return 32'(sa >>> sh);
        else                 return 32'd0;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".result"}, Result, exp_res);
        check({tag, ".zero"}, {31'd0, Zero}, {31'd0, exp_zero});
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    endtask

    // Drive one cycle of inputs, let the edge capture them, then compare.
    task automatic step(input string tag, input logic v, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b);
        in_valid   = v;
        ALUControl = c;
        A          = a;
        B          = b;
        @(posedge clk);
        #1;
        if (v) begin
            exp_res  = model(c, a, b);
            exp_zero = (exp_res == 32'd0);
            exp_ov   = 1'b1;
        end else begin
            exp_ov = 1'b0;
        end
        check_outputs(tag);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        A          = 32'd0;
        B          = 32'd0;
        ALUControl = 4'd0;
        exp_res    = 32'd0;
        exp_zero   = 1'b1;
        exp_ov     = 1'b0;
        #7;
        check_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        step("add",      1'b1, 4'd2,  32'h10,       32'h20);
        check("add_lit", Result, 32'h30);
        step("sub",      1'b1, 4'd6,  32'h30,       32'h10);
        check("sub_lit", Result, 32'h20);
        step("sub_zero", 1'b1, 4'd6,  32'd5,        32'd5);
        step("add_wrap", 1'b1, 4'd2,  32'hFFFFFFFF, 32'd1);
        check("wrap_zero", {31'd0, Zero}, 32'd1);
        step("and",      1'b1, 4'd0,  32'hF0F0F0F0, 32'h0F0F0F0F);
        step("or",       1'b1, 4'd1,  32'hF0F0F0F0, 32'h0F0F0F0F);
        step("xor",      1'b1, 4'd3,  32'hF0F0F0F0, 32'h0F0F0F0F);
        check("xor_lit", Result, 32'hFFFFFFFF);
        step("sll",      1'b1, 4'd8,  32'd1,        32'd2);
        step("srl",      1'b1, 4'd9,  32'h10,       32'd2);
        step("sra",      1'b1, 4'd10, 32'hF0000000, 32'd4);
        check("sra_lit", Result, 32'hFF000000);
        step("sll_mask", 1'b1, 4'd8,  32'd1,        32'h21);
        check("sll_mask_lit", Result, 32'h2);
        step("sll_0",    1'b1, 4'd8,  32'h8000_0001, 32'd0);
        step("sra_31",   1'b1, 4'd10, 32'h8000_0000, 32'd31);
        step("srl_31",   1'b1, 4'd9,  32'h8000_0000, 32'hFFFF_FFFF);
        step("slt_neg",  1'b1, 4'd7,  32'hFFFFFFFF, 32'd1);
        check("slt_lit", Result, 32'd1);
        step("slt_min",  1'b1, 4'd7,  32'h80000000, 32'h0);
        step("slt_max",  1'b1, 4'd7,  32'h7FFFFFFF, 32'h80000000);
        step("undef",    1'b1, 4'd15, 32'd1,        32'd1);
        step("undef4",   1'b1, 4'd4,  32'd3,        32'd9);
        step("xor_nz",   1'b1, 4'd3,  32'h1234,     32'h0);
        step("hold",     1'b0, 4'd2,  32'hDEAD,     32'hBEEF);
        step("hold2",    1'b0, 4'd6,  32'h0,        32'h1);
        step("b2b_add",  1'b1, 4'd2,  32'd100,      32'd23);
        step("b2b_sub",  1'b1, 4'd6,  32'd100,      32'd23);
        step("b2b_xor",  1'b1, 4'd3,  32'hAAAA,     32'h5555);

        // Asynchronous reset between edges, held across a valid edge.
        #3;
        rst = 1'b1;
        #1;
        exp_res  = 32'd0;
        exp_zero = 1'b1;
        exp_ov   = 1'b0;
        check_outputs("async_rst");
        in_valid   = 1'b1;
        ALUControl = 4'd2;
        A          = 32'd7;
        B          = 32'd8;
        @(posedge clk);
        #1;
        check_outputs("rst_held");
        #3;
        rst = 1'b0;
        step("post_rst_hold",  1'b0, 4'd2, 32'd7, 32'd8);
        step("post_rst_hold2", 1'b0, 4'd1, 32'd1, 32'd2);
        step("post_rst_op",    1'b1, 4'd1, 32'h100, 32'h3);

        for (int i = 0; i < 400; i++) begin
            logic        v;
            logic [3:0]  c;
            logic [31:0] a;
            logic [31:0] b;
            v = ($urandom_range(0, 3) != 0);
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'h8000_0000;
                1: b = a;
                2: b = 32'($urandom_range(0, 40));
                default: a = a;
            endcase
            step("rand", v, c, a, b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 32-bit registered arithmetic/logic unit for the datapath execute stage.
- Computes one of nine operations on operands A and B, selected by a 4-bit ALUControl code.
- Registers Result and a Zero flag one clock after a valid input.
- Single clock domain; asynchronous active-high reset.

Parameters:
- WIDTH, 32, operand and result width in bits (shift amount field is log2(WIDTH) bits; only 32 needs to be supported).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A/B/ALUControl are valid this cycle; launch an operation.
- A  input  32  operand A (shifted value for shift ops).
- B  input  32  operand B (shift amount in B[4:0] for shift ops).
- ALUControl  input  4  operation select.
- Result  output  32  registered operation result.
- Zero  output  1  registered flag, 1 when Result == 0.
- out_valid  output  1  Result/Zero updated by an operation captured on the previous edge.

Behaviour:
- Interface is fixed: one clock (clk); reset rst is asynchronous and active-high.
- Reset, applied immediately on rst assertion regardless of clk:
  - Result = 0, Zero = 1, out_valid = 0.
  - Any operation in flight is discarded.
  - First capture is on the first rising edge with rst low and in_valid high.
- Latency is 1 cycle. On a rising edge with in_valid = 1:
  - Result <= f(A, B, ALUControl).
  - Zero <= (f == 0).
  - out_valid <= 1.
- On a rising edge with in_valid = 0: Result and Zero hold their previous values; out_valid <= 0.
- No backpressure. A new operation can be accepted every cycle (full throughput).
- Operation encoding (all arithmetic is modulo 2^32; carries and overflow are discarded):
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B
  - 0011 XOR: A ^ B
  - 0110 SUB: A - B (two's complement)
  - 0111 SLT: 32'd1 if signed(A) < signed(B), else 32'd0
  - 1000 SLL: A << B[4:0], zero fill
  - 1001 SRL: A >> B[4:0], zero fill
  - 1010 SRA: A >>> B[4:0], fill with A[31]
  - All other codes (0100, 0101, 1011–1111): Result = 0, Zero = 1.
- Shift boundaries:
  - B[31:5] is ignored.
  - Shift amount 0 passes A unchanged.
  - Shift amount 31 is the maximum.
- Zero is derived from the same-cycle computed value, never from the stale registered Result.
- SLT boundary: A = 0x80000000, B = 0x00000000 -> 1; A = 0x7FFFFFFF, B = 0x80000000 -> 0.
- Inputs that change while in_valid is low have no effect on the outputs.

Test Plan:
- rst pulse mid-stream, asynchronous and between clock edges -> Result = 0, Zero = 1, out_valid = 0 immediately; outputs hold through the following cycles until an in_valid cycle.
- Arithmetic, in_valid = 1, one cycle each:
  - ADD 0x10 + 0x20 -> 0x00000030, Zero = 0.
  - SUB 0x30 - 0x10 -> 0x00000020.
  - SUB 5 - 5 -> 0, Zero = 1.
  - ADD 0xFFFFFFFF + 1 -> 0, Zero = 1.
  - out_valid = 1 one cycle after each input.
- Logic with A = 0xF0F0F0F0, B = 0x0F0F0F0F:
  - AND -> 0x00000000, Zero = 1.
  - OR -> 0xFFFFFFFF.
  - XOR -> 0xFFFFFFFF, Zero = 0.
- Shifts:
  - SLL A = 1, B = 2 -> 0x00000004.
  - SRL A = 0x10, B = 2 -> 0x00000004.
  - SRA A = 0xF0000000, B = 4 -> 0xFF000000.
  - SLL A = 1, B = 0x00000021 -> 0x00000002 (only B[4:0] used).
- SLT, undefined code and hold:
  - SLT A = 0xFFFFFFFF (−1), B = 1 -> 0x00000001.
  - ALUControl = 1111, A = B = 1 -> Result = 0, Zero = 1.
  - Next cycle in_valid = 0 with changed inputs -> Result/Zero hold, out_valid = 0.
- Back-to-back throughput: ADD, SUB, XOR on consecutive cycles -> three consecutive correct results, out_valid high for three cycles.
